// File: rtl/fir_pkg.sv
// Shared constants, FSM state encoding and output rounding for the
// coefficient-bank single-MAC FIR.
package fir_pkg;

    localparam int NTAPS  = 61;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 7;
    localparam int ACC_W  = 38;
    localparam int FRAC   = 15;
    localparam int PROD_W = 2 * DATA_W;
    localparam int IDX_W  = $clog2(NTAPS);

    localparam logic [ADDR_W-1:0] NTAPS_A  = ADDR_W'(NTAPS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NTAPS - 1);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Round half-up to Q1.15 and clamp to the signed 16-bit range.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic [DATA_W-1:0]       result;
        shifted = (acc + RND_HALF) >>> FRAC;
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_coef_mac_bank.sv
// Coefficient register bank: one synchronous write port with address range
// check, one combinational read port for the MAC.
module fir_coef_bank
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              err,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [NTAPS];
    logic [DATA_W-1:0] mem_d [NTAPS];
    logic              in_range;

    assign in_range = (waddr < NTAPS_A);
    assign err      = we && !in_range;

    // Next bank contents: only an in-range write changes one entry.
    always_comb begin
        mem_d = mem_q;
        if (we && in_range) begin
            mem_d[waddr[IDX_W-1:0]] = wdata;
        end
    end

    // Bank register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Indices past the last tap never occur during a MAC; read them as zero.
    assign rdata = (raddr <= LAST_IDX) ? mem_q[raddr] : '0;

endmodule

// File: rtl/fir_coef_mac.sv
// Coefficient consumer of the ROM-to-RAM loader link plus a time-multiplexed
// single-MAC low-pass FIR producing one output per accepted sample.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting; coefficient writes and new samples are accepted
// ST_MAC  | one tap per cycle, acc += coef[k] * x[k], k = 0..NTAPS-1
// ST_DONE | round/saturate acc into filter_out, pulse out_valid
module fir_coef_mac
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wren,
    input  logic [ADDR_W-1:0] a_ram,
    input  logic [DATA_W-1:0] coef_in,
    input  logic [DATA_W-1:0] filter_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] filter_out,
    output logic              out_valid,
    output logic              coef_ready,
    output logic              busy,
    output logic              overrun,
    output logic              coef_err
);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] x_q [NTAPS];
    logic signed [DATA_W-1:0] x_d [NTAPS];
    logic [DATA_W-1:0]        filter_out_q, filter_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     coef_ready_q, coef_ready_d;
    logic                     overrun_q, overrun_d;
    logic                     coef_err_q, coef_err_d;

    logic                     idle;
    logic                     bank_we;
    logic                     bank_err;
    logic [DATA_W-1:0]        coef_rdata;
    logic signed [PROD_W-1:0] prod;

    assign idle    = (state_q == ST_IDLE);
    // Writes are only let into the bank while idle so a running MAC never
    // sees its coefficients change underneath it.
    assign bank_we = wren && idle;

    fir_coef_bank u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we),
        .waddr (a_ram),
        .wdata (coef_in),
        .err   (bank_err),
        .raddr (k_q),
        .rdata (coef_rdata)
    );

    assign prod = PROD_W'($signed(coef_rdata)) * PROD_W'(x_q[k_q]);

    // Next-state, datapath and flag logic.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        acc_d        = acc_q;
        x_d          = x_q;
        filter_out_d = filter_out_q;
        out_valid_d  = 1'b0;
        coef_ready_d = coef_ready_q;
        overrun_d    = overrun_q;
        coef_err_d   = coef_err_q;

        if (bank_we && !bank_err && (a_ram == '0)) begin
            coef_ready_d = 1'b1;
        end
        if ((wren && !idle) || bank_err) begin
            coef_err_d = 1'b1;
        end
        if (sample_valid && !idle) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_valid && coef_ready_q) begin
                    for (int i = NTAPS - 1; i > 0; i--) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0]  = $signed(filter_in);
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
                if (k_q == LAST_IDX) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                filter_out_d = sat16(acc_q);
                out_valid_d  = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also aborts a MAC in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            acc_q        <= '0;
            x_q          <= '{default: '0};
            filter_out_q <= '0;
            out_valid_q  <= 1'b0;
            coef_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            coef_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            x_q          <= x_d;
            filter_out_q <= filter_out_d;
            out_valid_q  <= out_valid_d;
            coef_ready_q <= coef_ready_d;
            overrun_q    <= overrun_d;
            coef_err_q   <= coef_err_d;
        end
    end

    assign filter_out = filter_out_q;
    assign out_valid  = out_valid_q;
    assign coef_ready = coef_ready_q;
    assign busy       = !idle;
    assign overrun    = overrun_q;
    assign coef_err   = coef_err_q;

endmodule

// File: tb/tb_fir_coef_mac.sv
// Self-checking bench for fir_coef_mac: constant vector table for the impulse
// response, plus random coefficients/samples against a sum-of-products model.
module tb_fir_coef_mac;
    import fir_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              wren;
    logic [ADDR_W-1:0] a_ram;
    logic [DATA_W-1:0] coef_in;
    logic [DATA_W-1:0] filter_in;
    logic              sample_valid;
    logic [DATA_W-1:0] filter_out;
    logic              out_valid;
    logic              coef_ready;
    logic              busy;
    logic              overrun;
    logic              coef_err;

    fir_coef_mac dut (
        .clk          (clk),
        .reset        (reset),
        .wren         (wren),
        .a_ram        (a_ram),
        .coef_in      (coef_in),
        .filter_in    (filter_in),
        .sample_valid (sample_valid),
        .filter_out   (filter_out),
        .out_valid    (out_valid),
        .coef_ready   (coef_ready),
        .busy         (busy),
        .overrun      (overrun),
        .coef_err     (coef_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sample;
        int expect_out;
    } vec_t;

    vec_t vecs[NTAPS];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   coef_m[NTAPS];   // reference bank contents (signed)
    int   hist[NTAPS];     // reference delay line, hist[0] newest
    int   coef_t[NTAPS];   // coefficient set to load next

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_out();
        longint s = 0;
        for (int k = 0; k < NTAPS; k++) begin
            s += longint'(coef_m[k]) * longint'(hist[k]);
        end
        s = (s + 16384) >>> 15;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return int'(s) & 32'hFFFF;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NTAPS; i++) begin
            coef_m[i] = 0;
            hist[i]   = 0;
        end
    endtask

    task automatic model_shift(input logic [DATA_W-1:0] x);
        for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'($signed(x));
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        wren         = 1'b0;
        sample_valid = 1'b0;
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int addr, input logic [DATA_W-1:0] data, input bit upd);
        a_ram   = ADDR_W'(addr);
        coef_in = data;
        wren    = 1'b1;
        tick();
        wren = 1'b0;
        if (upd && addr < NTAPS) coef_m[addr] = int'($signed(data));
    endtask

    task automatic load_bank();
        for (int a = NTAPS - 1; a >= 0; a--) write_coef(a, 16'(coef_t[a]), 1'b1);
    endtask

    task automatic wait_out(output int lat, output int val);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: got no out_valid expected one within 200 cycles");
        end
        val = int'(filter_out);
    endtask

    task automatic send_and_wait(input logic [DATA_W-1:0] x, output int val, output int lat);
        filter_in    = x;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        model_shift(x);
        wait_out(lat, val);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int val, lat, pulses;
        logic [DATA_W-1:0] x;

        for (int i = 0; i < NTAPS; i++) begin
            vecs[i].sample     = (i == 0) ? 32'h7FFF : 0;
            vecs[i].expect_out = 16 * i;
        end

        reset = 1'b1; wren = 1'b0; sample_valid = 1'b0;
        a_ram = '0; coef_in = '0; filter_in = '0;
        tick(); tick();
        reset = 1'b0;
        model_clear();

        check("rst_filter_out", int'(filter_out), 0);
        check("rst_out_valid",  int'(out_valid), 0);
        check("rst_coef_ready", int'(coef_ready), 0);
        check("rst_busy",       int'(busy), 0);
        check("rst_overrun",    int'(overrun), 0);
        check("rst_coef_err",   int'(coef_err), 0);

        // Sample before the bank is loaded is silently ignored.
        filter_in = 16'h1234; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("busy_not_ready", int'(busy), 0);
        pulses = 0;
        repeat (70) begin
            if (out_valid) pulses++;
            tick();
        end
        check("no_out_not_ready", pulses, 0);
        check("overrun_not_ready", int'(overrun), 0);

        // Out-of-range write addresses.
        write_coef(61, 16'h5555, 1'b1);
        check("err_addr61", int'(coef_err), 1);
        check("ready_addr61", int'(coef_ready), 0);
        do_reset();
        check("err_cleared", int'(coef_err), 0);
        write_coef(127, 16'h5555, 1'b1);
        check("err_addr127", int'(coef_err), 1);
        do_reset();

        // Scenario 1: single unity-ish tap.
        for (int i = 0; i < NTAPS; i++) coef_t[i] = 0;
        coef_t[0] = 32'h7FFF;
        for (int a = NTAPS - 1; a > 0; a--) write_coef(a, 16'(coef_t[a]), 1'b1);
        check("ready_before_addr0", int'(coef_ready), 0);
        write_coef(0, 16'(coef_t[0]), 1'b1);
        check("ready_after_addr0", int'(coef_ready), 1);
        send_and_wait(16'h1000, val, lat);
        check("s1_value", val, 32'h1000);
        check("s1_latency", lat, NTAPS + 1);
        tick();
        check("s1_pulse_width", int'(out_valid), 0);
        check("s1_hold", int'(filter_out), 32'h1000);
        check("s1_coef_err", int'(coef_err), 0);

        // Scenario 2: impulse response of coef[k] = 16k, table driven.
        do_reset();
        for (int i = 0; i < NTAPS; i++) coef_t[i] = 16 * i;
        load_bank();
        for (int i = 0; i < NTAPS; i++) begin
            send_and_wait(16'(vecs[i].sample), val, lat);
            check("impulse_tap", val, vecs[i].expect_out);
        end

        // Scenario 3: saturation both directions.
        for (int i = 0; i < NTAPS; i++) coef_t[i] = 32'h4000;
        load_bank();
        for (int i = 0; i < NTAPS; i++) begin
            send_and_wait(16'h7FFF, val, lat);
            check("sat_pos_model", val, model_out());
        end
        check("sat_pos_final", val, 32'h7FFF);
        for (int i = 0; i < NTAPS; i++) begin
            send_and_wait(16'h8000, val, lat);
            check("sat_neg_model", val, model_out());
        end
        check("sat_neg_final", val, 32'h8000);

        // Random coefficients and samples, back to back.
        do_reset();
        for (int i = 0; i < NTAPS; i++) coef_t[i] = int'($urandom_range(0, 65535)) - 32768;
        load_bank();
        for (int n = 0; n < 16; n++) begin
            send_and_wait(16'($urandom_range(0, 65535)), val, lat);
            check("rand_value", val, model_out());
            check("rand_latency", lat, NTAPS + 1);
        end

        // Write and sample in the same idle cycle: new coefficient is used.
        a_ram = '0; coef_in = 16'h7000; wren = 1'b1;
        filter_in = 16'h4000; sample_valid = 1'b1;
        tick();
        wren = 1'b0; sample_valid = 1'b0;
        coef_m[0] = 32'h7000;
        model_shift(16'h4000);
        wait_out(lat, val);
        check("simul_wr_value", val, model_out());
        check("simul_wr_err", int'(coef_err), 0);

        // Overrun: second sample 10 cycles into the MAC is dropped.
        x = 16'($urandom_range(0, 65535));
        filter_in = x; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        model_shift(x);
        repeat (9) tick();
        filter_in = 16'($urandom_range(0, 65535)); sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("overrun_set", int'(overrun), 1);
        check("overrun_busy", int'(busy), 1);
        wait_out(lat, val);
        check("overrun_latency", lat + 10, NTAPS + 1);
        check("overrun_value", val, model_out());
        pulses = 0;
        repeat (80) begin
            tick();
            if (out_valid) pulses++;
        end
        check("overrun_single_out", pulses, 0);

        // Write during MAC is rejected and leaves the bank untouched.
        check("err_before_mac_wr", int'(coef_err), 0);
        x = 16'($urandom_range(0, 65535));
        filter_in = x; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        model_shift(x);
        repeat (5) tick();
        write_coef(5, 16'h1234, 1'b0);
        check("err_mac_wr", int'(coef_err), 1);
        wait_out(lat, val);
        check("mac_wr_value", val, model_out());
        for (int n = 0; n < 3; n++) begin
            send_and_wait(16'($urandom_range(0, 65535)), val, lat);
            check("bank_unchanged", val, model_out());
        end

        // Reset in the middle of a MAC.
        filter_in = 16'h2345; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check("midrst_busy", int'(busy), 0);
        check("midrst_filter_out", int'(filter_out), 0);
        check("midrst_coef_ready", int'(coef_ready), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        pulses = 0;
        repeat (80) begin
            if (out_valid) pulses++;
            tick();
        end
        check("midrst_no_out", pulses, 0);

        // Reload scenario 1 after the abort.
        for (int i = 0; i < NTAPS; i++) coef_t[i] = 0;
        coef_t[0] = 32'h7FFF;
        load_bank();
        check("reload_ready", int'(coef_ready), 1);
        send_and_wait(16'h1000, val, lat);
        check("reload_value", val, 32'h1000);
        check("reload_latency", lat, NTAPS + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
